// File: rtl/ctrl_pipeline_pkg.sv
// Control-word types shared by the pipeline control block and its hazard logic.
// E carries the full execute-stage control set; M and W keep only what those stages consume.
package mips_decls_p;

    localparam int REG_ADDR_W   = 5;
    localparam int ALU_CTRL_W   = 3;
    localparam int BUBBLE_CNT_W = 16;

    typedef struct packed {
        logic                  regwrite;
        logic                  memtoreg;
        logic                  memwrite;
        logic                  branch;
        logic                  alusrc;
        logic                  regdst;
        logic [ALU_CTRL_W-1:0] alucontrol;
    } ctrl_e_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic memwrite;
    } ctrl_m_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
    } ctrl_w_t;

    // A bubble must carry no write enables and no branch, so all-zero is the safe encoding.
    localparam ctrl_e_t CTRL_BUBBLE = '0;

    localparam logic [BUBBLE_CNT_W-1:0] BUBBLE_CNT_MAX = '1;

    function automatic ctrl_m_t e_to_m(input ctrl_e_t e);
        ctrl_m_t m;
        m.regwrite = e.regwrite;
        m.memtoreg = e.memtoreg;
        m.memwrite = e.memwrite;
        return m;
    endfunction

    function automatic ctrl_w_t m_to_w(input ctrl_m_t m);
        ctrl_w_t w;
        w.regwrite = m.regwrite;
        w.memtoreg = m.memtoreg;
        return w;
    endfunction

    function automatic logic [BUBBLE_CNT_W-1:0] sat_inc(input logic [BUBBLE_CNT_W-1:0] v);
        return (v == BUBBLE_CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ctrl_pipeline_if.sv
// Bundle of decode inputs, datapath feedback and per-stage control/hazard outputs.
// master drives the decode side and datapath feedback; slave is the pipeline control block.
interface ctrl_pipeline_if;
    import mips_decls_p::*;

    logic                    regwrite_d;
    logic                    memtoreg_d;
    logic                    memwrite_d;
    logic                    branch_d;
    logic                    alusrc_d;
    logic                    regdst_d;
    logic                    jump_d;
    logic [ALU_CTRL_W-1:0]   alucontrol_d;
    logic [REG_ADDR_W-1:0]   rs_d;
    logic [REG_ADDR_W-1:0]   rt_d;
    logic [REG_ADDR_W-1:0]   writereg_e;
    logic                    zero_e;

    logic                    regwrite_e;
    logic                    memtoreg_e;
    logic                    memwrite_e;
    logic                    branch_e;
    logic                    alusrc_e;
    logic                    regdst_e;
    logic [ALU_CTRL_W-1:0]   alucontrol_e;
    logic                    regwrite_m;
    logic                    memtoreg_m;
    logic                    memwrite_m;
    logic                    regwrite_w;
    logic                    memtoreg_w;
    logic                    pcsrc_e;
    logic                    stall_f;
    logic                    stall_d;
    logic                    flush_d;
    logic                    flush_e;
    logic [BUBBLE_CNT_W-1:0] bubble_cnt;

    modport master (
        output regwrite_d, memtoreg_d, memwrite_d, branch_d, alusrc_d, regdst_d, jump_d,
        output alucontrol_d, rs_d, rt_d, writereg_e, zero_e,
        input  regwrite_e, memtoreg_e, memwrite_e, branch_e, alusrc_e, regdst_e, alucontrol_e,
        input  regwrite_m, memtoreg_m, memwrite_m, regwrite_w, memtoreg_w,
        input  pcsrc_e, stall_f, stall_d, flush_d, flush_e, bubble_cnt
    );

    modport slave (
        input  regwrite_d, memtoreg_d, memwrite_d, branch_d, alusrc_d, regdst_d, jump_d,
        input  alucontrol_d, rs_d, rt_d, writereg_e, zero_e,
        output regwrite_e, memtoreg_e, memwrite_e, branch_e, alusrc_e, regdst_e, alucontrol_e,
        output regwrite_m, memtoreg_m, memwrite_m, regwrite_w, memtoreg_w,
        output pcsrc_e, stall_f, stall_d, flush_d, flush_e, bubble_cnt
    );

endinterface

// File: rtl/ctrl_pipeline_hazard.sv
// Combinational load-use and taken-branch hazard detection; zero latency.
// A taken branch wins over a load-use stall: the wrong-path decode slot is flushed, not held.
module hazard_unit
    import mips_decls_p::*;
(
    input  logic                  i_memtoreg_e,
    input  logic                  i_regwrite_e,
    input  logic                  i_branch_e,
    input  logic                  i_zero_e,
    input  logic                  i_jump_d,
    input  logic [REG_ADDR_W-1:0] i_writereg_e,
    input  logic [REG_ADDR_W-1:0] i_rs_d,
    input  logic [REG_ADDR_W-1:0] i_rt_d,
    output logic                  o_pcsrc_e,
    output logic                  o_stall_f,
    output logic                  o_stall_d,
    output logic                  o_flush_d,
    output logic                  o_flush_e
);

    logic w_src_match;
    logic w_lwstall;

    // Register 0 is hardwired, so a load targeting it never creates a real dependency.
    assign w_src_match = (i_writereg_e == i_rs_d) || (i_writereg_e == i_rt_d);
    assign w_lwstall   = i_memtoreg_e && i_regwrite_e
                      && (i_writereg_e != '0) && w_src_match;

    assign o_pcsrc_e = i_branch_e && i_zero_e;
    assign o_stall_f = w_lwstall && !o_pcsrc_e;
    assign o_stall_d = w_lwstall && !o_pcsrc_e;
    assign o_flush_e = w_lwstall || o_pcsrc_e;
    // A jump stuck behind a load-use stall stays in decode and redirects once the stall clears.
    assign o_flush_d = o_pcsrc_e || (i_jump_d && !w_lwstall);

endmodule

// File: rtl/ctrl_pipeline.sv
// Control-word pipeline D->E->M->W (1/2/3-cycle latency) with hazard-driven E-stage bubbles.
// No backpressure: M/W always advance; E loads a bubble whenever flush_e is raised.
module ctrl_pipeline
    import mips_decls_p::*;
(
    input  logic           clk,
    input  logic           reset,
    ctrl_pipeline_if.slave bus
);

    ctrl_e_t                 r_ctrl_e;
    ctrl_m_t                 r_ctrl_m;
    ctrl_w_t                 r_ctrl_w;
    logic [BUBBLE_CNT_W-1:0] r_bubble_cnt;

    ctrl_e_t w_ctrl_d;
    logic    w_pcsrc_e;
    logic    w_stall_f;
    logic    w_stall_d;
    logic    w_flush_d;
    logic    w_flush_e;

    assign w_ctrl_d.regwrite   = bus.regwrite_d;
    assign w_ctrl_d.memtoreg   = bus.memtoreg_d;
    assign w_ctrl_d.memwrite   = bus.memwrite_d;
    assign w_ctrl_d.branch     = bus.branch_d;
    assign w_ctrl_d.alusrc     = bus.alusrc_d;
    assign w_ctrl_d.regdst     = bus.regdst_d;
    assign w_ctrl_d.alucontrol = bus.alucontrol_d;

    hazard_unit u_hazard (
        .i_memtoreg_e (r_ctrl_e.memtoreg),
        .i_regwrite_e (r_ctrl_e.regwrite),
        .i_branch_e   (r_ctrl_e.branch),
        .i_zero_e     (bus.zero_e),
        .i_jump_d     (bus.jump_d),
        .i_writereg_e (bus.writereg_e),
        .i_rs_d       (bus.rs_d),
        .i_rt_d       (bus.rt_d),
        .o_pcsrc_e    (w_pcsrc_e),
        .o_stall_f    (w_stall_f),
        .o_stall_d    (w_stall_d),
        .o_flush_d    (w_flush_d),
        .o_flush_e    (w_flush_e)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctrl_e     <= CTRL_BUBBLE;
            r_ctrl_m     <= '0;
            r_ctrl_w     <= '0;
            r_bubble_cnt <= '0;
        end else begin
            r_ctrl_e <= w_flush_e ? CTRL_BUBBLE : w_ctrl_d;
            r_ctrl_m <= e_to_m(r_ctrl_e);
            r_ctrl_w <= m_to_w(r_ctrl_m);
            if (w_flush_e) begin
                r_bubble_cnt <= sat_inc(r_bubble_cnt);
            end
        end
    end

    assign bus.regwrite_e   = r_ctrl_e.regwrite;
    assign bus.memtoreg_e   = r_ctrl_e.memtoreg;
    assign bus.memwrite_e   = r_ctrl_e.memwrite;
    assign bus.branch_e     = r_ctrl_e.branch;
    assign bus.alusrc_e     = r_ctrl_e.alusrc;
    assign bus.regdst_e     = r_ctrl_e.regdst;
    assign bus.alucontrol_e = r_ctrl_e.alucontrol;

    assign bus.regwrite_m   = r_ctrl_m.regwrite;
    assign bus.memtoreg_m   = r_ctrl_m.memtoreg;
    assign bus.memwrite_m   = r_ctrl_m.memwrite;

    assign bus.regwrite_w   = r_ctrl_w.regwrite;
    assign bus.memtoreg_w   = r_ctrl_w.memtoreg;

    assign bus.pcsrc_e      = w_pcsrc_e;
    assign bus.stall_f      = w_stall_f;
    assign bus.stall_d      = w_stall_d;
    assign bus.flush_d      = w_flush_d;
    assign bus.flush_e      = w_flush_e;
    assign bus.bubble_cnt   = r_bubble_cnt;

endmodule
